// File: rtl/junction_pkg.sv
// Shared encodings and the round-robin pick helper for the junction request path
// and the traffic light controller.
package junction_pkg;

    typedef logic [1:0] dir_t;

    localparam int NUM_DIR              = 4;
    localparam int DEBOUNCE_CNT_DEFAULT = 4;

    localparam dir_t DIR_S = 2'd0;
    localparam dir_t DIR_W = 2'd1;
    localparam dir_t DIR_N = 2'd2;
    localparam dir_t DIR_E = 2'd3;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } pick_t;

    // First requesting approach after 'last', wrapping; dir falls back to 'last' when none.
    function automatic pick_t rr_pick(input logic [NUM_DIR-1:0] req, input dir_t last);
        pick_t p;
        dir_t  d;
        p.valid = 1'b0;
        p.dir   = last;
        for (int i = 1; i <= NUM_DIR; i++) begin
            d = last + dir_t'(i);
            if (!p.valid && req[d]) begin
                p.valid = 1'b1;
                p.dir   = d;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/junction_debounce.sv
// One demand channel: 2-flop synchroniser, tick-sampled debounce counter,
// stable level and a one-cycle pulse on its rising edge.
module junction_debounce
    import junction_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
    input  logic clk1,
    input  logic reset_n,
    input  logic sample_tick,
    input  logic req_raw,
    output logic rise
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CNT - 1);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] cnt;
    logic       stable;
    logic       stable_d;

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= req_raw;
            sync_p1 <= sync_p0;
        end
    end

    // A new level must disagree with the stable one on DEBOUNCE_CNT consecutive ticks.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 4'd0;
            stable <= 1'b0;
        end else if (sample_tick) begin
            if (sync_p1 == stable) begin
                cnt <= 4'd0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/junction_demand_detector.sv
// Debounced per-approach demand latch with round-robin next-approach selection.
// Optional per-approach wait counters and wait_s port: define JUNCTION_WAIT_CNT_EN.
module junction_demand_detector
    import junction_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT,
    parameter int WAIT_W       = 8
) (
    input  logic               clk1,
    input  logic               reset_n,
    input  logic               sample_tick,
    input  logic [NUM_DIR-1:0] req_raw,
    input  logic               serve_valid,
    input  dir_t               serve_dir,
    output logic [NUM_DIR-1:0] pending,
    output logic               next_valid,
    output dir_t               next_dir
`ifdef JUNCTION_WAIT_CNT_EN
    ,
    input  logic               sec_tick,
    output logic [WAIT_W-1:0]  wait_s
`endif
);

    if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15 || WAIT_W < 1) begin : g_bad_param
        $error("junction_demand_detector: DEBOUNCE_CNT must be 1..15 and WAIT_W >= 1");
    end

    logic [NUM_DIR-1:0] rise;
    logic [NUM_DIR-1:0] clr;
    dir_t               last_served;
    pick_t              pick;

    for (genvar i = 0; i < NUM_DIR; i++) begin : g_ch
        junction_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_debounce (
            .clk1        (clk1),
            .reset_n     (reset_n),
            .sample_tick (sample_tick),
            .req_raw     (req_raw[i]),
            .rise        (rise[i])
        );
    end

    always_comb begin
        clr = '0;
        if (serve_valid) begin
            clr[serve_dir] = 1'b1;
        end
    end

    // A rise in the same cycle as a serve of that approach wins over the clear.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= '0;
            last_served <= DIR_E;
        end else begin
            pending <= (pending & ~clr) | rise;
            if (serve_valid) begin
                last_served <= serve_dir;
            end
        end
    end

    assign pick = rr_pick(pending, last_served);

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            next_valid <= 1'b0;
            next_dir   <= DIR_S;
        end else begin
            next_valid <= pick.valid;
            if (pick.valid) begin
                next_dir <= pick.dir;
            end
        end
    end

`ifdef JUNCTION_WAIT_CNT_EN
    logic [WAIT_W-1:0] wait_cnt [NUM_DIR];

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIR; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIR; i++) begin
                if (clr[i]) begin
                    wait_cnt[i] <= '0;
                end else if (sec_tick && pending[i]) begin
                    wait_cnt[i] <= sat_inc(wait_cnt[i]);
                end
            end
        end
    end

    // Registered alongside next_dir so both describe the same approach.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            wait_s <= '0;
        end else begin
            wait_s <= pick.valid ? wait_cnt[pick.dir] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_junction_demand_detector.sv
// Directed bench for junction_demand_detector (DEBOUNCE_CNT=4, sample_tick every 10 clk1).
module tb_junction_demand_detector;

    logic       clk1;
    logic       reset_n;
    logic       sample_tick;
    logic [3:0] req_raw;
    logic       serve_valid;
    logic [1:0] serve_dir;
    logic [3:0] pending;
    logic       next_valid;
    logic [1:0] next_dir;
`ifdef JUNCTION_WAIT_CNT_EN
    logic       sec_tick;
    logic [3:0] wait_s;
`endif

    int errors = 0;
    int checks = 0;

    junction_demand_detector #(
        .DEBOUNCE_CNT (4),
        .WAIT_W       (4)
    ) dut (
        .clk1        (clk1),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .req_raw     (req_raw),
        .serve_valid (serve_valid),
        .serve_dir   (serve_dir),
        .pending     (pending),
        .next_valid  (next_valid),
        .next_dir    (next_dir)
`ifdef JUNCTION_WAIT_CNT_EN
        ,
        .sec_tick    (sec_tick),
        .wait_s      (wait_s)
`endif
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            idle(9);
            sample_tick = 1'b1;
            idle(1);
            sample_tick = 1'b0;
        end
    endtask

    task automatic serve(input logic [1:0] d);
        serve_valid = 1'b1;
        serve_dir   = d;
        idle(1);
        serve_valid = 1'b0;
    endtask

    task automatic do_reset();
        req_raw     = 4'b0000;
        serve_valid = 1'b0;
        serve_dir   = 2'd0;
        sample_tick = 1'b0;
`ifdef JUNCTION_WAIT_CNT_EN
        sec_tick    = 1'b0;
`endif
        reset_n     = 1'b0;
        idle(2);
        reset_n     = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending: got %b want 0000", pending); end
        checks++;
        if (next_valid !== 1'b0) begin errors++; $display("FAIL rst_next_valid: got %b want 0", next_valid); end
        checks++;
        if (next_dir !== 2'd0) begin errors++; $display("FAIL rst_next_dir: got %0d want 0", next_dir); end
    endtask

    task automatic test_single_request();
        do_reset();
        req_raw = 4'b0100;
        run_ticks(4);
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL t1_pending_early: got %b want 0000", pending); end
        idle(1);
        checks++;
        if (pending !== 4'b0100) begin errors++; $display("FAIL t1_pending: got %b want 0100", pending); end
        checks++;
        if (next_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_latency: got %b want 0", next_valid); end
        idle(1);
        checks++;
        if (next_valid !== 1'b1) begin errors++; $display("FAIL t1_next_valid: got %b want 1", next_valid); end
        checks++;
        if (next_dir !== 2'd2) begin errors++; $display("FAIL t1_next_dir: got %0d want 2", next_dir); end
    endtask

    task automatic test_glitch();
        do_reset();
        req_raw = 4'b0001;
        run_ticks(2);
        req_raw = 4'b0000;
        run_ticks(4);
        idle(2);
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL t2_pending: got %b want 0000", pending); end
        checks++;
        if (next_valid !== 1'b0) begin errors++; $display("FAIL t2_next_valid: got %b want 0", next_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_raw = 4'b1111;
        run_ticks(4);
        idle(1);
        checks++;
        if (pending !== 4'b1111) begin errors++; $display("FAIL t3_pending_all: got %b want 1111", pending); end
        idle(1);
        checks++;
        if (next_dir !== 2'd0 || next_valid !== 1'b1) begin
            errors++; $display("FAIL t3_first: got dir %0d valid %b want dir 0 valid 1", next_dir, next_valid);
        end
        serve(2'd0);
        checks++;
        if (pending !== 4'b1110) begin errors++; $display("FAIL t3_clear0: got %b want 1110", pending); end
        checks++;
        if (next_dir !== 2'd0) begin errors++; $display("FAIL t3_dir_latency: got %0d want 0", next_dir); end
        idle(1);
        checks++;
        if (next_dir !== 2'd1) begin errors++; $display("FAIL t3_dir1: got %0d want 1", next_dir); end
        serve(2'd1);
        idle(1);
        checks++;
        if (next_dir !== 2'd2) begin errors++; $display("FAIL t3_dir2: got %0d want 2", next_dir); end
        serve(2'd2);
        idle(1);
        checks++;
        if (next_dir !== 2'd3) begin errors++; $display("FAIL t3_dir3: got %0d want 3", next_dir); end
        serve(2'd3);
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL t3_clear_all: got %b want 0000", pending); end
        idle(1);
        checks++;
        if (next_valid !== 1'b0) begin errors++; $display("FAIL t3_valid_end: got %b want 0", next_valid); end
        checks++;
        if (next_dir !== 2'd3) begin errors++; $display("FAIL t3_dir_hold: got %0d want 3", next_dir); end
    endtask

    task automatic test_set_wins();
        do_reset();
        req_raw = 4'b0110;
        run_ticks(4);
        serve_valid = 1'b1;
        serve_dir   = 2'd1;
        idle(1);
        serve_valid = 1'b0;
        checks++;
        if (pending !== 4'b0110) begin errors++; $display("FAIL t4_pending: got %b want 0110", pending); end
        idle(1);
        checks++;
        if (next_valid !== 1'b1) begin errors++; $display("FAIL t4_next_valid: got %b want 1", next_valid); end
        checks++;
        if (next_dir !== 2'd2) begin errors++; $display("FAIL t4_last_served: got next_dir %0d want 2", next_dir); end
    endtask

    task automatic test_reset_midway();
        do_reset();
        req_raw = 4'b1010;
        run_ticks(4);
        idle(2);
        checks++;
        if (pending !== 4'b1010 || next_dir !== 2'd1) begin
            errors++; $display("FAIL t5_setup: got pending %b dir %0d want 1010 dir 1", pending, next_dir);
        end
        req_raw = 4'b1011;
        run_ticks(3);
        idle(1);
        reset_n = 1'b0;
        #1;
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL t5_async_pending: got %b want 0000", pending); end
        checks++;
        if (next_valid !== 1'b0 || next_dir !== 2'd0) begin
            errors++; $display("FAIL t5_async_next: got valid %b dir %0d want 0 0", next_valid, next_dir);
        end
        idle(2);
        reset_n = 1'b1;
        run_ticks(3);
        idle(1);
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL t5_redebounce_early: got %b want 0000", pending); end
        run_ticks(1);
        idle(1);
        checks++;
        if (pending !== 4'b1011) begin errors++; $display("FAIL t5_redetect: got %b want 1011", pending); end
        idle(1);
        checks++;
        if (next_dir !== 2'd0 || next_valid !== 1'b1) begin
            errors++; $display("FAIL t5_next: got dir %0d valid %b want 0 1", next_dir, next_valid);
        end
    endtask

`ifdef JUNCTION_WAIT_CNT_EN
    task automatic sec_pulses(input int n);
        repeat (n) begin
            sec_tick = 1'b1;
            idle(1);
            sec_tick = 1'b0;
            idle(1);
        end
    endtask

    task automatic test_wait_count();
        do_reset();
        req_raw = 4'b0001;
        run_ticks(4);
        idle(2);
        checks++;
        if (wait_s !== 4'd0) begin errors++; $display("FAIL t6_wait_start: got %0d want 0", wait_s); end
        sec_pulses(5);
        checks++;
        if (wait_s !== 4'd5) begin errors++; $display("FAIL t6_wait5: got %0d want 5", wait_s); end
        sec_pulses(15);
        checks++;
        if (wait_s !== 4'd15) begin errors++; $display("FAIL t6_wait_sat: got %0d want 15", wait_s); end
        serve(2'd0);
        idle(1);
        checks++;
        if (wait_s !== 4'd0) begin errors++; $display("FAIL t6_wait_clear: got %0d want 0", wait_s); end
    endtask
`endif

    initial begin
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        req_raw     = 4'b0000;
        serve_valid = 1'b0;
        serve_dir   = 2'd0;
`ifdef JUNCTION_WAIT_CNT_EN
        sec_tick    = 1'b0;
`endif
        test_reset();
        test_single_request();
        test_glitch();
        test_round_robin();
        test_set_wins();
        test_reset_midway();
`ifdef JUNCTION_WAIT_CNT_EN
        test_wait_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
